// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter
// Round-robin sequencer that shares one port of dpram_36x1024 between NREQ
// requesters. Each grant becomes a single rce/wce pulse on the RAM port. A read
// result is captured RD_LAT cycles after the ISSUE cycle and handed back to the
// winner with a one-cycle rsp_valid strobe. Only one transaction is in flight.
// All outputs come straight from flops.
//
// Optional feature macro: DPRAM_PORT_ARBITER_STATS_EN
//   When defined, adds saturating 16-bit counters: stat_grants (one per
//   requester, packed) and stat_stall (cycles with a request pending while busy).

module dpram_port_arbiter #(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 36,
    parameter int NREQ   = 2,
    parameter int RD_LAT = 1
) (
    input  logic                     clock0,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*AWIDTH-1:0]   req_addr,
    input  logic [NREQ*DWIDTH-1:0]   req_wd,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DWIDTH-1:0]        rsp_data,
    output logic                     ram_rce,
    output logic                     ram_wce,
    output logic [AWIDTH-1:0]        ram_addr,
    output logic [DWIDTH-1:0]        ram_wd,
    input  logic [DWIDTH-1:0]        ram_rq
`ifdef DPRAM_PORT_ARBITER_STATS_EN
    ,
    output logic [NREQ*16-1:0]       stat_grants,
    output logic [15:0]              stat_stall
`else
`endif
);

    localparam int              IDW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int              CW       = 3;
    localparam logic [IDW:0]    NREQ_X   = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0]  ID_LAST  = IDW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // State and transaction latch
    state_t             r_state;
    logic [IDW-1:0]     r_rr_ptr;
    logic [IDW-1:0]     r_id;
    logic               r_we;
    logic [CW-1:0]      r_wait_cnt;

    // Registered outputs
    logic [NREQ-1:0]    r_gnt;
    logic [NREQ-1:0]    r_rsp_valid;
    logic [DWIDTH-1:0]  r_rsp_data;
    logic               r_ram_rce;
    logic               r_ram_wce;
    logic [AWIDTH-1:0]  r_ram_addr;
    logic [DWIDTH-1:0]  r_ram_wd;

    // Next-state / next-output values
    state_t             w_state_nxt;
    logic [IDW-1:0]     w_rr_nxt;
    logic [IDW-1:0]     w_id_nxt;
    logic               w_we_nxt;
    logic [CW-1:0]      w_wait_nxt;
    logic [NREQ-1:0]    w_gnt_nxt;
    logic [NREQ-1:0]    w_rsp_valid_nxt;
    logic [DWIDTH-1:0]  w_rsp_data_nxt;
    logic               w_rce_nxt;
    logic               w_wce_nxt;
    logic [AWIDTH-1:0]  w_addr_nxt;
    logic [DWIDTH-1:0]  w_wd_nxt;

    // Arbitration helpers
    logic               w_win_found;
    logic [IDW-1:0]     w_win_id;
    logic [IDW:0]       w_idx_ext;
    logic [IDW-1:0]     w_rr_inc;

    assign gnt       = r_gnt;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign ram_rce   = r_ram_rce;
    assign ram_wce   = r_ram_wce;
    assign ram_addr  = r_ram_addr;
    assign ram_wd    = r_ram_wd;

    // Round-robin search: first active requester starting at r_rr_ptr, wrapping mod NREQ
    always_comb begin
        w_win_found = 1'b0;
        w_win_id    = '0;
        w_idx_ext   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx_ext = {1'b0, r_rr_ptr} + (IDW+1)'(k);
            if (w_idx_ext >= NREQ_X) begin
                w_idx_ext = w_idx_ext - NREQ_X;
            end else begin
                w_idx_ext = w_idx_ext;
            end
            if (!w_win_found && req[w_idx_ext[IDW-1:0]]) begin
                w_win_found = 1'b1;
                w_win_id    = w_idx_ext[IDW-1:0];
            end else begin
                w_win_found = w_win_found;
            end
        end
    end

    // Pointer value that follows the current winner, wrapping at NREQ-1
    always_comb begin
        if (r_id == ID_LAST) begin
            w_rr_inc = '0;
        end else begin
            w_rr_inc = r_id + IDW'(1);
        end
    end

    // FSM next state and next registered outputs
    always_comb begin
        w_state_nxt     = r_state;
        w_rr_nxt        = r_rr_ptr;
        w_id_nxt        = r_id;
        w_we_nxt        = r_we;
        w_wait_nxt      = r_wait_cnt;
        w_gnt_nxt       = '0;
        w_rsp_valid_nxt = '0;
        w_rsp_data_nxt  = r_rsp_data;
        w_rce_nxt       = 1'b0;
        w_wce_nxt       = 1'b0;
        w_addr_nxt      = '0;
        w_wd_nxt        = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_win_found) begin
                    w_state_nxt = ST_ISSUE;
                    w_id_nxt    = w_win_id;
                    w_we_nxt    = req_we[w_win_id];
                    w_gnt_nxt   = ONE_HOT0 << w_win_id;
                    w_wce_nxt   = req_we[w_win_id];
                    w_rce_nxt   = ~req_we[w_win_id];
                    w_addr_nxt  = req_addr[w_win_id*AWIDTH +: AWIDTH];
                    w_wd_nxt    = req_wd[w_win_id*DWIDTH +: DWIDTH];
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                w_rr_nxt = w_rr_inc;
                if (r_we) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT;
                    w_wait_nxt  = CW'(RD_LAT - 1);
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_state_nxt     = ST_RESP;
                    w_rsp_data_nxt  = ram_rq;
                    w_rsp_valid_nxt = ONE_HOT0 << r_id;
                end else begin
                    w_wait_nxt = r_wait_cnt - CW'(1);
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, latch and output registers with synchronous active-low reset
    always_ff @(posedge clock0) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_we        <= 1'b0;
            r_wait_cnt  <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_ram_rce   <= 1'b0;
            r_ram_wce   <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wd    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_id        <= w_id_nxt;
            r_we        <= w_we_nxt;
            r_wait_cnt  <= w_wait_nxt;
            r_gnt       <= w_gnt_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_ram_rce   <= w_rce_nxt;
            r_ram_wce   <= w_wce_nxt;
            r_ram_addr  <= w_addr_nxt;
            r_ram_wd    <= w_wd_nxt;
        end
    end

`ifdef DPRAM_PORT_ARBITER_STATS_EN
    logic [NREQ*16-1:0] r_stat_grants;
    logic [15:0]        r_stat_stall;

    assign stat_grants = r_stat_grants;
    assign stat_stall  = r_stat_stall;

    // Saturating per-requester grant counters and busy-stall counter
    always_ff @(posedge clock0) begin
        if (!reset_n) begin
            r_stat_grants <= '0;
            r_stat_stall  <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if ((r_state == ST_ISSUE) && (r_id == IDW'(i)) &&
                    (r_stat_grants[i*16 +: 16] != 16'hFFFF)) begin
                    r_stat_grants[i*16 +: 16] <= r_stat_grants[i*16 +: 16] + 16'd1;
                end
            end
            if ((|req) && (r_state != ST_IDLE) && (r_stat_stall != 16'hFFFF)) begin
                r_stat_stall <= r_stat_stall + 16'd1;
            end
        end
    end
`else
    // Statistics counters not built in this configuration.
`endif

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter with a behavioural 1-cycle RAM and a
// reference array. Inputs are driven and outputs sampled on falling edges.

module tb_dpram_port_arbiter;

    localparam int AW  = 10;
    localparam int DW  = 36;
    localparam int NR  = 2;
    localparam int RDL = 1;

    logic              clock0   = 1'b0;
    logic              reset_n  = 1'b0;
    logic [NR-1:0]     req      = '0;
    logic [NR-1:0]     req_we   = '0;
    logic [NR*AW-1:0]  req_addr = '0;
    logic [NR*DW-1:0]  req_wd   = '0;
    logic [NR-1:0]     gnt;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              ram_rce;
    logic              ram_wce;
    logic [AW-1:0]     ram_addr;
    logic [DW-1:0]     ram_wd;
    logic [DW-1:0]     ram_rq   = '0;
`ifdef DPRAM_PORT_ARBITER_STATS_EN
    logic [NR*16-1:0]  stat_grants;
    logic [15:0]       stat_stall;
`endif

    logic [DW-1:0] mem     [1024];
    logic [DW-1:0] ref_mem [1024];

    int n_tests = 0;
    int n_fail  = 0;
    int n_both  = 0;

    dpram_port_arbiter #(
        .AWIDTH (AW),
        .DWIDTH (DW),
        .NREQ   (NR),
        .RD_LAT (RDL)
    ) dut (
        .clock0    (clock0),
        .reset_n   (reset_n),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wd    (req_wd),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .ram_rce   (ram_rce),
        .ram_wce   (ram_wce),
        .ram_addr  (ram_addr),
        .ram_wd    (ram_wd),
        .ram_rq    (ram_rq)
`ifdef DPRAM_PORT_ARBITER_STATS_EN
        ,
        .stat_grants (stat_grants),
        .stat_stall  (stat_stall)
`endif
    );

    always #5 clock0 = ~clock0;

    // Behavioural RAM port: registered read, one cycle after rce
    always @(posedge clock0) begin
        if (ram_wce === 1'b1) mem[ram_addr] <= ram_wd;
        if (ram_rce === 1'b1) ram_rq <= mem[ram_addr];
    end

    // Count any cycle where both RAM strobes are high
    always @(negedge clock0) begin
        if (ram_rce === 1'b1 && ram_wce === 1'b1) n_both++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance at least one cycle, then until any gnt is seen (bounded)
    task automatic wait_gnt(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clock0);
            n++;
        end while (gnt === '0 && n < 64);
        chk({tag, "_gnt_bound"}, 64'(n < 64), 64'd1);
    endtask

    // One complete transaction for requester r; returns read data
    task automatic do_op(input int r, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input string tag,
                         output logic [DW-1:0] rd);
        int lat;
        logic [NR-1:0] oh;
        oh = '0;
        oh[r] = 1'b1;
        rd = '0;
        req_we[r] = we;
        req_addr[r*AW +: AW] = a;
        req_wd[r*DW +: DW] = d;
        req[r] = 1'b1;
        wait_gnt(tag);
        chk({tag, "_gnt"}, 64'(gnt), 64'(oh));
        chk({tag, "_wce"}, 64'(ram_wce), 64'(we));
        chk({tag, "_rce"}, 64'(ram_rce), 64'(!we));
        chk({tag, "_addr"}, 64'(ram_addr), 64'(a));
        if (we) chk({tag, "_wd"}, 64'(ram_wd), 64'(d));
        req[r] = 1'b0;
        if (we) begin
            ref_mem[a] = d;
            @(negedge clock0);
            chk({tag, "_wce_off"}, 64'(ram_wce), 64'd0);
            chk({tag, "_addr_off"}, 64'(ram_addr), 64'd0);
        end else begin
            // gnt cycle counts as cycle 1; response expected in cycle 2+RD_LAT
            lat = 1;
            do begin
                @(negedge clock0);
                lat++;
            end while (rsp_valid === '0 && lat < 16);
            chk({tag, "_rsp_lat"}, 64'(lat), 64'(2 + RDL));
            chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(oh));
            chk({tag, "_rsp_data"}, 64'(rsp_data), 64'(ref_mem[a]));
            rd = rsp_data;
        end
    endtask

    initial begin
        logic [DW-1:0] rd;
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        logic          we;
        int            c0;
        int            c1;

        for (int i = 0; i < 1024; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end

        // Reset held with both requesting reads
        req_we = 2'b00;
        req_addr[0 +: AW]  = 10'd5;
        req_addr[AW +: AW] = 10'd6;
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock0);
            chk("rst_gnt", 64'(gnt), 64'd0);
            chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("rst_rce", 64'(ram_rce), 64'd0);
            chk("rst_wce", 64'(ram_wce), 64'd0);
        end
        reset_n = 1'b1;
        wait_gnt("first");
        chk("first_gnt", 64'(gnt), 64'h1);
        req = 2'b00;
        repeat (6) @(negedge clock0);

        // All requests low: outputs stay idle
        for (int i = 0; i < 3; i++) begin
            @(negedge clock0);
            chk("idle_gnt", 64'(gnt), 64'd0);
            chk("idle_rce", 64'(ram_rce), 64'd0);
            chk("idle_wce", 64'(ram_wce), 64'd0);
            chk("idle_addr", 64'(ram_addr), 64'd0);
            chk("idle_rsp", 64'(rsp_valid), 64'd0);
        end

        // Write then read by requester 0 at address 0
        do_op(0, 1'b1, 10'd0, 36'haaaaaaaaa, "wr0", rd);
        do_op(0, 1'b0, 10'd0, 36'h0, "rd0", rd);
        chk("rd0_value", 64'(rd), 64'haaaaaaaaa);

        // Cross-requester ordering at address 1023 with rr_ptr=1
        req_we = 2'b10;
        req_addr[0 +: AW]  = 10'd1023;
        req_addr[AW +: AW] = 10'd1023;
        req_wd[DW +: DW]   = 36'hbbbbbbbbb;
        req = 2'b11;
        wait_gnt("x_first");
        chk("x_first_gnt", 64'(gnt), 64'h2);
        chk("x_first_wce", 64'(ram_wce), 64'd1);
        req[1] = 1'b0;
        ref_mem[1023] = 36'hbbbbbbbbb;
        wait_gnt("x_second");
        chk("x_second_gnt", 64'(gnt), 64'h1);
        chk("x_second_rce", 64'(ram_rce), 64'd1);
        chk("x_second_addr", 64'(ram_addr), 64'd1023);
        req[0] = 1'b0;
        c0 = 0;
        do begin
            @(negedge clock0);
            c0++;
        end while (rsp_valid === '0 && c0 < 16);
        chk("x_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("x_rsp_data", 64'(rsp_data), 64'hbbbbbbbbb);
        do_op(1, 1'b0, 10'd1023, 36'h0, "x_rd1", rd);
        chk("x_rd1_value", 64'(rd), 64'hbbbbbbbbb);

        // Fairness: both hold write requests for 8 grants, rr_ptr starts at 0
        req_we = 2'b11;
        req_addr[0 +: AW]  = 10'd100;
        req_addr[AW +: AW] = 10'd200;
        req_wd[0 +: DW]    = 36'h111111111;
        req_wd[DW +: DW]   = 36'h222222222;
        req = 2'b11;
        c0 = 0;
        c1 = 0;
        for (int g = 0; g < 8; g++) begin
            wait_gnt("fair");
            chk("fair_seq", 64'(gnt), (g % 2 == 0) ? 64'h1 : 64'h2);
            if (gnt === 2'b01) c0++;
            if (gnt === 2'b10) c1++;
        end
        req = 2'b00;
        ref_mem[100] = 36'h111111111;
        ref_mem[200] = 36'h222222222;
        chk("fair_cnt0", 64'(c0), 64'd4);
        chk("fair_cnt1", 64'(c1), 64'd4);
        repeat (2) @(negedge clock0);

        // Reset asserted while a read is in WAIT
        req_we[0] = 1'b0;
        req_addr[0 +: AW] = 10'd0;
        req[0] = 1'b1;
        wait_gnt("mid");
        chk("mid_gnt", 64'(gnt), 64'h1);
        req[0] = 1'b0;
        @(negedge clock0);
        reset_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock0);
            chk("mid_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("mid_gnt_quiet", 64'(gnt), 64'd0);
            chk("mid_rce_quiet", 64'(ram_rce), 64'd0);
            if (i == 1) reset_n = 1'b1;
        end
        do_op(0, 1'b0, 10'd0, 36'h0, "post_rst_rd", rd);
        chk("post_rst_value", 64'(rd), 64'haaaaaaaaa);

        // Random soak against the reference array
        for (int i = 0; i < 2 * 1024; i++) begin
            we = 1'($urandom_range(0, 1));
            a  = AW'($urandom_range(0, 31));
            d[31:0]  = $urandom();
            d[35:32] = 4'($urandom());
            do_op(i % 2, we, a, d, "soak", rd);
        end

        chk("rce_wce_exclusive", 64'(n_both), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
